// File: rtl/scan_pkg.sv
// Package: scan_pkg
// Shared types, default parameters and channel-wrap helper for the
// scan_sel_seq channel-select sequencer.
package scan_pkg;

    // Default configuration
    localparam int SEL_W_DEF  = 3;
    localparam int NUM_CH_DEF = 8;
    localparam int DWELL_DEF  = 4;

    // State encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIN  = ST_FIN
    } state_t;

    // Widest select the helper handles; callers cast to their own width
    localparam int MAX_SEL_W = 16;
    typedef logic [MAX_SEL_W-1:0] ch_t;

    // Next channel with wrap at num_ch-1 (up) or at 0 (down)
    function automatic ch_t next_ch(input ch_t sel, input logic dir, input int num_ch);
        ch_t last;
        last = ch_t'(num_ch - 1);
        if (!dir) begin
            next_ch = (sel == last) ? '0 : sel + ch_t'(1);
        end else begin
            next_ch = (sel == '0) ? last : sel - ch_t'(1);
        end
    endfunction

endpackage

// File: rtl/scan_sel_seq_dwell_timer.sv
// Module: dwell_timer
// Free-running modulo-DWELL counter; expire marks the last cycle of a dwell.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    // Count 0..DWELL-1 while enabled, restart from 0 on clear
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/scan_sel_seq.sv
// Module: scan_sel_seq
// Channel-select sequencer feeding a SEL_W-to-2**SEL_W decoder. Holds each
// channel for DWELL cycles and scans NUM_CH channels up or down from start_ch.
// Optional feature macro: SCAN_PINGPONG_EN -- bounce between the ends of the
// channel range indefinitely instead of finishing after a single scan.
module scan_sel_seq
    import scan_pkg::*;
#(
    parameter int SEL_W  = SEL_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DWELL  = DWELL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [SEL_W-1:0] start_ch,
    output logic [SEL_W-1:0] sel,
    output logic             sel_vld,
    output logic             step,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_t           state;
    logic             dir_q;
    logic [SEL_W-1:0] ch_cnt;
    logic             expire;
    logic             tmr_clr;
    logic             tmr_en;
    logic [SEL_W-1:0] sel_adv;

    // Dwell timer runs only while scanning and sits at 0 otherwise
    assign tmr_en  = (state == RUN);
    assign tmr_clr = (state != RUN);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (expire)
    );

    assign sel_adv = SEL_W'(next_ch(ch_t'(sel), dir_q, NUM_CH));

`ifdef SCAN_PINGPONG_EN
    logic [SEL_W-1:0] sel_turn;

    // Neighbour of the end channel, stepping in the reversed direction
    assign sel_turn = SEL_W'(next_ch(ch_t'(sel), ~dir_q, NUM_CH));
`endif

    // Scan FSM with registered select, handshake and pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dir_q   <= 1'b0;
            ch_cnt  <= '0;
            sel     <= '0;
            sel_vld <= 1'b0;
            step    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state   <= RUN;
                        sel     <= start_ch;
                        dir_q   <= dir;
                        ch_cnt  <= '0;
                        sel_vld <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        sel_vld <= 1'b0;
                        busy    <= 1'b0;
                    end else if (expire) begin
                        if (ch_cnt != LAST_CH) begin
                            sel    <= sel_adv;
                            ch_cnt <= ch_cnt + SEL_W'(1);
                            step   <= 1'b1;
                        end else begin
`ifdef SCAN_PINGPONG_EN
                            // The end channel counts as the first of the next pass
                            dir_q  <= ~dir_q;
                            sel    <= sel_turn;
                            ch_cnt <= SEL_W'(1);
                            step   <= 1'b1;
                            done   <= 1'b1;
`else
                            state   <= FIN;
                            sel_vld <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
`endif
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
